imm_instr_encoder: RTL

IMM_INSTR_ENCODER -- requirements
Module: imm_instr_encoder

---
 rtl/imm_instr_encoder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/imm_instr_encoder.sv
// imm_instr_encoder: two-stage RV32 instruction encoder with immediate range checking
// Ports: CLK/RESETN (async active-low) clock and reset; IN_VALID/IN_READY request handshake;
// FORMAT, OPCODE, RD, RS1, RS2, FUNCT3, FUNCT7, IMM instruction fields; OUT_VALID/OUT_READY
// result handshake; OUT_INSTR encoded word; OUT_ERR range/format error; ENC_COUNT/ERR_COUNT
// saturating counters of emitted words and emitted error words.
module imm_instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       FORMAT,
    input  logic [6:0]       OPCODE,
    input  logic [4:0]       RD,
    input  logic [4:0]       RS1,
    input  logic [4:0]       RS2,
    input  logic [2:0]       FUNCT3,
    input  logic [6:0]       FUNCT7,
    input  logic [31:0]      IMM,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      OUT_INSTR,
    output logic             OUT_ERR,
    output logic [CNT_W-1:0] ENC_COUNT,
    output logic [CNT_W-1:0] ERR_COUNT
);
    logic        s1_valid;
    logic [2:0]  s1_fmt;
    logic [6:0]  s1_op;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_f3;
    logic [6:0]  s1_f7;
    logic [31:0] s1_imm;
    logic [31:0] enc_word;
    logic        enc_err;
    logic        accept;
    logic        s1_adv;
    logic        out_hs;
    logic        i_ok;
    logic        b_ok;
    logic        j_ok;
    assign IN_READY = RESETN && (!s1_valid || !OUT_VALID || OUT_READY);
    assign accept   = IN_VALID && IN_READY;
    assign out_hs   = OUT_VALID && OUT_READY;
    assign s1_adv   = s1_valid && (!OUT_VALID || OUT_READY);
    // An immediate fits when every bit above the field's sign bit copies that sign bit
    assign i_ok = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
    assign b_ok = ((&s1_imm[31:12]) || !(|s1_imm[31:12])) && !s1_imm[0];
    assign j_ok = ((&s1_imm[31:20]) || !(|s1_imm[31:20])) && !s1_imm[0];
    always_comb begin
        enc_word = '0;
        enc_err  = 1'b1;
        case (s1_fmt)
            3'd0: begin
                enc_word = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
                enc_err  = 1'b0;
            end
            3'd1: begin
                enc_word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
                enc_err  = !i_ok;
            end
            3'd2: begin
                enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
                enc_err  = !i_ok;
            end
            3'd3: begin
                enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                            s1_imm[4:1], s1_imm[11], s1_op};
                enc_err  = !b_ok;
            end
            3'd4: begin
                enc_word = {s1_imm[31:12], s1_rd, s1_op};
                enc_err  = |s1_imm[11:0];
            end
            3'd5: begin
                enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
                enc_err  = !j_ok;
            end
            default: ;
        endcase
    end
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= '0;
            s1_op     <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_f3     <= '0;
            s1_f7     <= '0;
            s1_imm    <= '0;
            OUT_VALID <= 1'b0;
            OUT_INSTR <= '0;
            OUT_ERR   <= 1'b0;
            ENC_COUNT <= '0;
            ERR_COUNT <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_fmt   <= FORMAT;
                s1_op    <= OPCODE;
                s1_rd    <= RD;
                s1_rs1   <= RS1;
                s1_rs2   <= RS2;
                s1_f3    <= FUNCT3;
                s1_f7    <= FUNCT7;
                s1_imm   <= IMM;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s1_adv) begin
                OUT_VALID <= 1'b1;
                OUT_INSTR <= enc_word;
                OUT_ERR   <= enc_err;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
            if (out_hs && !(&ENC_COUNT))
                ENC_COUNT <= ENC_COUNT + CNT_W'(1);
            if (out_hs && OUT_ERR && !(&ERR_COUNT))
                ERR_COUNT <= ERR_COUNT + CNT_W'(1);
        end
    end
endmodule
